alu_mul_sequencer: RTL and testbench

Multi-cycle controller that computes a 32-bit multiply by sequencing the shared single-cycle ALU through shift-and-add iterations. It sits beside the ALU in the single-cycle core. While it runs, it owns the ALU operand and opcode inputs through `alu_busy_o`, which the core uses to steer the ALU input muxes and stall the PC. Start and result use a request/acknowledge handshake.

---
 rtl/alu_mul_sequencer.sv | 107 ++++++++++
 tb/tb_alu_mul_sequencer.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/alu_mul_sequencer.sv
// alu_mul_sequencer: 32-bit shift-and-add multiply
// that drives the shared single-cycle ALU over several cycles.
module alu_mul_sequencer #(
  parameter int XLEN   = 32,
  parameter int ITER_W = 5
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic [XLEN-1:0]   a_i,
  input  logic [XLEN-1:0]   b_i,
  output logic              ready_o,
  output logic              valid_o,
  input  logic              ack_i,
  output logic [XLEN-1:0]   result_o,
  output logic              result_zero_o,
  output logic              alu_busy_o,
  output logic [XLEN-1:0]   alu_a_o,
  output logic [XLEN-1:0]   alu_b_o,
  output logic [3:0]        alu_op_o,
  input  logic [XLEN-1:0]   alu_c_i
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_NOP = 4'b0000;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   m_q, m_d;
  logic [XLEN-1:0]   q_q, q_d;
  logic [XLEN-1:0]   p_q, p_d;
  logic [ITER_W-1:0] cnt_q, cnt_d;

  logic run;
  assign run = (state_q == RUN);

  // State and datapath registers, cleared by reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      m_q     <= '0;
      q_q     <= '0;
      p_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      q_q     <= q_d;
      p_q     <= p_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: load on start, one add per RUN cycle,
  // leave early once no multiplier bits remain.
  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    q_d     = q_q;
    p_d     = p_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          m_d     = a_i;
          q_d     = b_i;
          p_d     = '0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        p_d   = alu_c_i;
        m_d   = m_q << 1;
        q_d   = q_q >> 1;
        cnt_d = cnt_q + ITER_W'(1);
        if (q_q[XLEN-1:1] == '0 || cnt_q == '1) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (ack_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake and ALU steering outputs.
  always_comb begin
    ready_o       = (state_q == IDLE);
    valid_o       = (state_q == DONE);
    alu_busy_o    = run;
    result_o      = p_q;
    result_zero_o = (p_q == '0);
    alu_a_o       = run ? p_q : '0;
    alu_b_o       = (run && q_q[0]) ? m_q : '0;
    alu_op_o      = run ? OP_ADD : OP_NOP;
  end

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// tb_alu_mul_sequencer: random and directed multiplies
// checked every cycle against a timing/arithmetic model.
module tb_alu_mul_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        ack = 1'b0;
  logic        ready, valid, rzero, busy;
  logic [31:0] result, alu_a, alu_b, alu_c;
  logic [3:0]  alu_op;

  int n_pass = 0;
  int n_tot  = 0;

  always #5 clk = ~clk;

  assign alu_c = (alu_op == 4'b0010) ? alu_a + alu_b : 32'h0;

  alu_mul_sequencer dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start),
    .a_i(a), .b_i(b), .ready_o(ready), .valid_o(valid),
    .ack_i(ack), .result_o(result),
    .result_zero_o(rzero), .alu_busy_o(busy),
    .alu_a_o(alu_a), .alu_b_o(alu_b),
    .alu_op_o(alu_op), .alu_c_i(alu_c)
  );

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h @%0t",
                  nm, act, exp, $time);
  endtask

  function automatic int nof(input logic [31:0] v);
    int n = 1;
    for (int i = 0; i < 32; i++) if (v[i]) n = i + 1;
    return n;
  endfunction

  // Model: 0 idle, 1 busy, 2 done.
  int          ms = 0;
  int          mk = 0;
  int          mn = 1;
  logic [31:0] ma = '0;
  logic [31:0] mb = '0;
  bit          mclr = 1'b1;
  bit          en = 1'b0;

  always @(posedge clk) begin
    en = 1'b1;
    if (!rst_n) begin
      ms = 0;
      mclr = 1'b1;
    end else begin
      case (ms)
        0: if (start) begin
          ma = a; mb = b; mk = 0; mn = nof(b);
          ms = 1; mclr = 1'b0;
        end
        1: begin
          mk++;
          if (mk == mn) ms = 2;
        end
        default: if (ack) ms = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    logic [63:0] msk;
    logic [31:0] prod;
    if (en) begin
      prod = ma * mb;
      chk("ready", {31'b0, ready}, {31'b0, ms == 0});
      chk("valid", {31'b0, valid}, {31'b0, ms == 2});
      chk("busy", {31'b0, busy}, {31'b0, ms == 1});
      chk("alu_op", {28'b0, alu_op},
          (ms == 1) ? 32'h2 : 32'h0);
      if (ms == 1) begin
        msk = (64'd1 << mk) - 64'd1;
        chk("alu_a", alu_a, ma * (mb & msk[31:0]));
        chk("alu_b", alu_b, mb[mk] ? (ma << mk) : 32'h0);
      end else begin
        chk("alu_a", alu_a, 32'h0);
        chk("alu_b", alu_b, 32'h0);
      end
      if (ms == 2) begin
        chk("result", result, prod);
        chk("rzero", {31'b0, rzero}, {31'b0, prod == 0});
      end
      if (ms == 0 && mclr) begin
        chk("rst_result", result, 32'h0);
        chk("rst_rzero", {31'b0, rzero}, 32'h1);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_mul(input logic [31:0] xa, xb,
                        input int hold, input bit poke,
                        input logic [31:0] eres,
                        input int en_cyc);
    int nb = 0;
    int g = 0;
    while (!ready && g < 50) begin step(); g++; end
    a = xa; b = xb; start = 1'b1;
    step();
    start = 1'b0;
    g = 0;
    while (!valid && g < 100) begin
      if (busy) nb++;
      step();
      g++;
    end
    chk("valid_seen", {31'b0, valid}, 32'h1);
    chk("busy_cycles", nb, en_cyc);
    chk("res_lit", result, eres);
    chk("rz_lit", {31'b0, rzero}, {31'b0, eres == 0});
    for (int i = 0; i < hold; i++) begin
      start = poke;
      a = $urandom; b = $urandom;
      step();
      chk("hold_res", result, eres);
      chk("hold_ready", {31'b0, ready}, 32'h0);
    end
    start = poke;
    ack = 1'b1;
    step();
    ack = 1'b0;
    start = 1'b0;
    chk("post_ack_ready", {31'b0, ready}, 32'h1);
  endtask

  initial begin
    logic [31:0] ra, rb;
    int g;
    step();
    step();
    rst_n = 1'b1;
    chk("r_ready", {31'b0, ready}, 32'h1);
    chk("r_valid", {31'b0, valid}, 32'h0);
    chk("r_busy", {31'b0, busy}, 32'h0);
    chk("r_result", result, 32'h0);
    chk("r_rzero", {31'b0, rzero}, 32'h1);
    chk("r_alu_op", {28'b0, alu_op}, 32'h0);

    do_mul(32'd3, 32'd5, 0, 1'b0, 32'd15, 3);
    do_mul(32'h12345678, 32'd0, 0, 1'b0, 32'd0, 1);
    do_mul(32'h12345678, 32'd1, 0, 1'b0, 32'h12345678, 1);
    do_mul(32'hFFFFFFFF, 32'hFFFFFFFF, 0, 1'b0, 32'd1, 32);
    do_mul(32'h80000000, 32'd2, 0, 1'b0, 32'd0, 2);
    do_mul(32'd7, 32'd6, 5, 1'b1, 32'd42, 3);
    do_mul(32'd2, 32'd2, 0, 1'b0, 32'd4, 2);

    a = 32'hFFFF; b = 32'hFFFF; start = 1'b1;
    step();
    start = 1'b0;
    repeat (10) step();
    chk("mid_busy", {31'b0, busy}, 32'h1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("mr_valid", {31'b0, valid}, 32'h0);
    chk("mr_busy", {31'b0, busy}, 32'h0);
    chk("mr_ready", {31'b0, ready}, 32'h1);
    chk("mr_result", result, 32'h0);
    chk("mr_alu_a", alu_a, 32'h0);
    chk("mr_alu_b", alu_b, 32'h0);
    do_mul(32'd3, 32'd5, 0, 1'b0, 32'd15, 3);

    for (int t = 0; t < 60; t++) begin
      ra = $urandom;
      rb = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 7) == 0) rb = 32'd0;
      do_mul(ra, rb, $urandom_range(0, 3),
             1'($urandom_range(0, 1)), ra * rb, nof(rb));
      g = $urandom_range(0, 2);
      repeat (g) step();
    end

    step();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
